// File: rtl/alu_packet_ctrl.sv
// alu_packet_ctrl: byte-stream packet engine between a UART rx and tx stream.
// Packets: opcode, reserved, len_lo, len_hi, payload. len counts the header.
// Opcodes: ECHO forwards the payload, ADD/SUB fold 32-bit LSB-first words
// into an accumulator and return it as 4 bytes; bad packets answer 0xEE.
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-low reset
//   rx_tdata   received byte
//   rx_tvalid  received byte valid
//   rx_tready  controller accepts the received byte
//   tx_tdata   byte to transmit
//   tx_tvalid  transmit byte valid
//   tx_tready  transmitter accepts the byte
//   busy_o     packet in progress (state not IDLE)
//   err_o      one-cycle pulse on protocol error or timeout
module alu_packet_ctrl #(
   parameter int unsigned TIMEOUT_P = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_tdata,
   input  logic       rx_tvalid,
   output logic       rx_tready,
   output logic [7:0] tx_tdata,
   output logic       tx_tvalid,
   input  logic       tx_tready,
   output logic       busy_o,
   output logic       err_o
);

   localparam logic [7:0] OP_ECHO = 8'hEC;
   localparam logic [7:0] OP_ADD  = 8'hA8;
   localparam logic [7:0] OP_SUB  = 8'hA9;
   localparam logic [7:0] ERR_BYTE = 8'hEE;

   localparam int CW = (TIMEOUT_P > 1) ? $clog2(TIMEOUT_P + 1) : 1;
   localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_P - 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_HDR1,
      S_LEN_LO,
      S_LEN_HI,
      S_ECHO_RX,
      S_ECHO_TX,
      S_OPERAND,
      S_DRAIN,
      S_SEND_RES,
      S_SEND_ERR
   } state_t;

   state_t        state_q;
   logic [7:0]    op_q;
   logic [7:0]    len_lo_q;
   logic [15:0]   rem_q;
   logic [31:0]   acc_q;
   logic [31:0]   word_q;
   logic [1:0]    bidx_q;
   logic          first_q;
   logic [1:0]    ridx_q;
   logic          buf_full_q;
   logic [7:0]    tx_data_q;
   logic          tx_valid_q;
   logic          err_q;
   logic [CW-1:0] tmo_q;

   logic          rdy_d;
   logic          wait_rx;
   logic          rx_fire;
   logic          tx_fire;
   logic          tmo_hit;
   logic [15:0]   len_full;
   logic [15:0]   rem_calc;
   logic          len_short;
   logic          is_arith;
   logic          arith_ok;
   logic [31:0]   word_d;
   logic [31:0]   acc_d;
   logic [7:0]    res_byte_d;

   // Ready decode from the registered state; forced low during reset.
   always_comb begin
      rdy_d   = 1'b0;
      wait_rx = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            rdy_d = 1'b1;
         end
         S_HDR1, S_LEN_LO, S_LEN_HI,
         S_OPERAND, S_DRAIN: begin
            rdy_d   = 1'b1;
            wait_rx = 1'b1;
         end
         S_ECHO_RX: begin
            rdy_d   = !buf_full_q;
            wait_rx = 1'b1;
         end
         default: begin
            rdy_d   = 1'b0;
            wait_rx = 1'b0;
         end
      endcase
   end

   assign rx_tready = rst & rdy_d;
   assign tx_tvalid = rst & tx_valid_q;
   assign tx_tdata  = tx_data_q;
   assign busy_o    = rst & (state_q != S_IDLE);
   assign err_o     = rst & err_q;

   assign rx_fire = rx_tvalid & rx_tready;
   assign tx_fire = tx_valid_q & tx_tready;

   // Abort after TIMEOUT_P consecutive cycles without an rx byte.
   assign tmo_hit = wait_rx & !rx_fire & (tmo_q == TMO_LAST);

   assign len_full  = {rx_tdata, len_lo_q};
   assign rem_calc  = len_full - 16'd4;
   assign len_short = len_full < 16'd4;
   assign is_arith  = (op_q == OP_ADD) | (op_q == OP_SUB);
   assign arith_ok  = is_arith & (rem_calc != 16'd0) &
                      (rem_calc[1:0] == 2'b00);

   // Words arrive LSB first: shift new bytes in at the top.
   assign word_d = {rx_tdata, word_q[31:8]};

   always_comb begin
      acc_d = acc_q;
      if (first_q)
         acc_d = word_d;
      else if (op_q == OP_SUB)
         acc_d = acc_q - word_d;
      else
         acc_d = acc_q + word_d;
   end

   // Next result byte after the one currently on tx_tdata.
   always_comb begin
      res_byte_d = acc_q[7:0];
      unique case (ridx_q)
         2'd0:    res_byte_d = acc_q[15:8];
         2'd1:    res_byte_d = acc_q[23:16];
         2'd2:    res_byte_d = acc_q[31:24];
         default: res_byte_d = acc_q[7:0];
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         op_q       <= 8'h00;
         len_lo_q   <= 8'h00;
         rem_q      <= 16'd0;
         acc_q      <= 32'd0;
         word_q     <= 32'd0;
         bidx_q     <= 2'd0;
         first_q    <= 1'b1;
         ridx_q     <= 2'd0;
         buf_full_q <= 1'b0;
         tx_data_q  <= 8'h00;
         tx_valid_q <= 1'b0;
         err_q      <= 1'b0;
         tmo_q      <= '0;
      end else begin
         err_q <= 1'b0;

         // Reload on any rx byte, count only while waiting for one.
         if (rx_fire)
            tmo_q <= '0;
         else if (wait_rx)
            tmo_q <= tmo_q + CW'(1);

         if (tmo_hit) begin
            state_q    <= S_IDLE;
            err_q      <= 1'b1;
            tmo_q      <= '0;
            buf_full_q <= 1'b0;
            tx_valid_q <= 1'b0;
         end else begin
            unique case (state_q)
               S_IDLE: begin
                  if (rx_fire) begin
                     op_q    <= rx_tdata;
                     state_q <= S_HDR1;
                  end
               end

               S_HDR1: begin
                  if (rx_fire)
                     state_q <= S_LEN_LO;
               end

               S_LEN_LO: begin
                  if (rx_fire) begin
                     len_lo_q <= rx_tdata;
                     state_q  <= S_LEN_HI;
                  end
               end

               S_LEN_HI: begin
                  if (rx_fire) begin
                     rem_q   <= rem_calc;
                     first_q <= 1'b1;
                     bidx_q  <= 2'd0;
                     word_q  <= 32'd0;
                     if (len_short) begin
                        state_q    <= S_SEND_ERR;
                        tx_data_q  <= ERR_BYTE;
                        tx_valid_q <= 1'b1;
                        err_q      <= 1'b1;
                     end else if (op_q == OP_ECHO) begin
                        if (rem_calc == 16'd0)
                           state_q <= S_IDLE;
                        else
                           state_q <= S_ECHO_RX;
                     end else if (arith_ok) begin
                        state_q <= S_OPERAND;
                     end else if (rem_calc == 16'd0) begin
                        state_q    <= S_SEND_ERR;
                        tx_data_q  <= ERR_BYTE;
                        tx_valid_q <= 1'b1;
                        err_q      <= 1'b1;
                     end else begin
                        state_q <= S_DRAIN;
                     end
                  end
               end

               S_ECHO_RX: begin
                  if (rx_fire) begin
                     tx_data_q  <= rx_tdata;
                     tx_valid_q <= 1'b1;
                     buf_full_q <= 1'b1;
                     rem_q      <= rem_q - 16'd1;
                     state_q    <= S_ECHO_TX;
                  end
               end

               S_ECHO_TX: begin
                  if (tx_fire) begin
                     tx_valid_q <= 1'b0;
                     buf_full_q <= 1'b0;
                     if (rem_q == 16'd0)
                        state_q <= S_IDLE;
                     else
                        state_q <= S_ECHO_RX;
                  end
               end

               S_OPERAND: begin
                  if (rx_fire) begin
                     rem_q  <= rem_q - 16'd1;
                     word_q <= word_d;
                     bidx_q <= bidx_q + 2'd1;
                     if (bidx_q == 2'd3) begin
                        acc_q   <= acc_d;
                        first_q <= 1'b0;
                     end
                     // Payload is a whole number of words, so the
                     // last byte always completes a word.
                     if (rem_q == 16'd1) begin
                        state_q    <= S_SEND_RES;
                        tx_data_q  <= acc_d[7:0];
                        tx_valid_q <= 1'b1;
                        ridx_q     <= 2'd0;
                     end
                  end
               end

               S_DRAIN: begin
                  if (rx_fire) begin
                     rem_q <= rem_q - 16'd1;
                     if (rem_q == 16'd1) begin
                        state_q    <= S_SEND_ERR;
                        tx_data_q  <= ERR_BYTE;
                        tx_valid_q <= 1'b1;
                        err_q      <= 1'b1;
                     end
                  end
               end

               S_SEND_RES: begin
                  if (tx_fire) begin
                     if (ridx_q == 2'd3) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= S_IDLE;
                     end else begin
                        tx_data_q <= res_byte_d;
                        ridx_q    <= ridx_q + 2'd1;
                     end
                  end
               end

               S_SEND_ERR: begin
                  if (tx_fire) begin
                     tx_valid_q <= 1'b0;
                     state_q    <= S_IDLE;
                  end
               end

               default: begin
                  state_q    <= S_IDLE;
                  tx_valid_q <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_alu_packet_ctrl.sv
// tb_alu_packet_ctrl: directed packets with hand-computed responses.
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
module tb_alu_packet_ctrl;

   localparam int TMO = 200;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] rx_tdata;
   logic       rx_tvalid;
   logic       rx_tready;
   logic [7:0] tx_tdata;
   logic       tx_tvalid;
   logic       tx_tready = 1'b1;
   logic       busy_o;
   logic       err_o;

   int n_assert = 0;
   int n_fail   = 0;
   int errs     = 0;
   int bp_mode  = 0;
   int lim      = 0;
   int stall    = 0;

   logic [7:0] txq[$];
   logic [7:0] pkt[$];
   logic       prev_stall = 1'b0;
   logic [7:0] prev_data  = 8'h00;

   alu_packet_ctrl #(.TIMEOUT_P(TMO)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_tdata  (rx_tdata),
      .rx_tvalid (rx_tvalid),
      .rx_tready (rx_tready),
      .tx_tdata  (tx_tdata),
      .tx_tvalid (tx_tvalid),
      .tx_tready (tx_tready),
      .busy_o    (busy_o),
      .err_o     (err_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Collect tx bytes, count err pulses, check tx hold under stall.
   always @(negedge clk) begin
      if (rst && prev_stall)
         chk("tx_hold", {23'd0, tx_tvalid, tx_tdata},
             {23'd0, 1'b1, prev_data});
      if (tx_tvalid && tx_tready)
         txq.push_back(tx_tdata);
      if (err_o)
         errs++;
      prev_stall = rst && tx_tvalid && !tx_tready;
      prev_data  = tx_tdata;
   end

   // tx_tready driver: 0 always ready, 1 stall 50 cycles per byte,
   // 2 ready only until lim bytes have been taken.
   always @(posedge clk) begin
      #1;
      case (bp_mode)
         0: tx_tready = 1'b1;
         1: begin
            if (tx_tready) begin
               tx_tready = 1'b0;
               stall = 0;
            end else if (tx_tvalid) begin
               stall++;
               if (stall >= 50)
                  tx_tready = 1'b1;
            end
         end
         default: tx_tready = (txq.size() < lim);
      endcase
   end

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int k;
      bit done;
      k = 0;
      done = 0;
      rx_tdata  = b;
      rx_tvalid = 1'b1;
      while (!done && k < 1000) begin
         @(negedge clk);
         if (rx_tready)
            done = 1;
         @(posedge clk);
         #1;
         k++;
      end
      rx_tvalid = 1'b0;
      if (!done)
         chk("rx_accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic send_pkt();
      foreach (pkt[i])
         send_byte(pkt[i]);
   endtask

   task automatic wait_tx(input int n);
      int k;
      k = 0;
      while (txq.size() < n && k < 2000) begin
         cyc(1);
         k++;
      end
      cyc(4);
   endtask

   task automatic clear();
      txq.delete();
      errs = 0;
   endtask

   function automatic logic [31:0] res32();
      logic [31:0] r;
      r = 32'hXXXXXXXX;
      if (txq.size() >= 4)
         r = {txq[3], txq[2], txq[1], txq[0]};
      return r;
   endfunction

   initial begin
      rst       = 1'b0;
      rx_tdata  = 8'h00;
      rx_tvalid = 1'b0;
      cyc(3);
      chk("rst_rx_tready", {31'd0, rx_tready}, 32'd0);
      chk("rst_tx_tvalid", {31'd0, tx_tvalid}, 32'd0);
      chk("rst_busy", {31'd0, busy_o}, 32'd0);
      chk("rst_err", {31'd0, err_o}, 32'd0);
      rst = 1'b1;
      cyc(1);
      chk("post_rst_ready", {31'd0, rx_tready}, 32'd1);

      // ADD 1 + 2
      clear();
      pkt = '{8'hA8, 8'h00, 8'h0C, 8'h00,
              8'h01, 8'h00, 8'h00, 8'h00,
              8'h02, 8'h00, 8'h00, 8'h00};
      send_pkt();
      chk("add_lat_valid", {31'd0, tx_tvalid}, 32'd1);
      chk("add_lat_data", {24'd0, tx_tdata}, 32'h03);
      wait_tx(4);
      chk("add_count", txq.size(), 32'd4);
      chk("add_result", res32(), 32'h00000003);
      chk("add_no_err", errs, 32'd0);
      chk("add_idle", {31'd0, busy_o}, 32'd0);

      // SUB 0 - 1 wraps
      clear();
      pkt = '{8'hA9, 8'h00, 8'h0C, 8'h00,
              8'h00, 8'h00, 8'h00, 8'h00,
              8'h01, 8'h00, 8'h00, 8'h00};
      send_pkt();
      wait_tx(4);
      chk("sub_count", txq.size(), 32'd4);
      chk("sub_wrap", res32(), 32'hFFFFFFFF);

      // ADD FFFFFFFF + 2 wraps
      clear();
      pkt = '{8'hA8, 8'h00, 8'h0C, 8'h00,
              8'hFF, 8'hFF, 8'hFF, 8'hFF,
              8'h02, 8'h00, 8'h00, 8'h00};
      send_pkt();
      wait_tx(4);
      chk("add_wrap", res32(), 32'h00000001);
      chk("add_wrap_err", errs, 32'd0);

      // ECHO with 50-cycle backpressure per byte
      clear();
      bp_mode = 1;
      pkt = '{8'hEC, 8'h00, 8'h07, 8'h00};
      send_pkt();
      send_byte(8'h41);
      chk("echo_lat_valid", {31'd0, tx_tvalid}, 32'd1);
      chk("echo_lat_data", {24'd0, tx_tdata}, 32'h41);
      send_byte(8'h42);
      send_byte(8'h43);
      wait_tx(3);
      bp_mode = 0;
      cyc(4);
      chk("echo_count", txq.size(), 32'd3);
      chk("echo_bytes", {8'd0, txq[0], txq[1], txq[2]}, 32'h00414243);
      chk("echo_no_err", errs, 32'd0);

      // Unknown opcode: payload drained, one error byte
      clear();
      pkt = '{8'h55, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB};
      send_pkt();
      chk("drain_lat_valid", {31'd0, tx_tvalid}, 32'd1);
      wait_tx(1);
      chk("drain_count", txq.size(), 32'd1);
      chk("drain_byte", {24'd0, txq[0]}, 32'hEE);
      chk("drain_err", errs, 32'd1);

      // ADD with a 2-byte payload
      clear();
      pkt = '{8'hA8, 8'h00, 8'h06, 8'h00, 8'h11, 8'h22};
      send_pkt();
      wait_tx(1);
      chk("badlen_count", txq.size(), 32'd1);
      chk("badlen_byte", {24'd0, txq[0]}, 32'hEE);
      chk("badlen_err", errs, 32'd1);

      // len below header size
      clear();
      pkt = '{8'hA8, 8'h00, 8'h02, 8'h00};
      send_pkt();
      chk("short_lat_valid", {31'd0, tx_tvalid}, 32'd1);
      wait_tx(1);
      chk("short_count", txq.size(), 32'd1);
      chk("short_byte", {24'd0, txq[0]}, 32'hEE);
      chk("short_err", errs, 32'd1);

      // ECHO with empty payload: nothing sent
      clear();
      pkt = '{8'hEC, 8'h00, 8'h04, 8'h00};
      send_pkt();
      cyc(5);
      chk("echo0_count", txq.size(), 32'd0);
      chk("echo0_idle", {31'd0, busy_o}, 32'd0);

      // Timeout mid-packet
      clear();
      pkt = '{8'hA8, 8'h00, 8'h0C, 8'h00, 8'h01};
      send_pkt();
      cyc(TMO - 2);
      chk("tmo_early_err", errs, 32'd0);
      chk("tmo_early_busy", {31'd0, busy_o}, 32'd1);
      cyc(12);
      chk("tmo_err", errs, 32'd1);
      chk("tmo_no_tx", txq.size(), 32'd0);
      chk("tmo_idle", {31'd0, busy_o}, 32'd0);
      clear();
      pkt = '{8'hA8, 8'h00, 8'h0C, 8'h00,
              8'h05, 8'h00, 8'h00, 8'h00,
              8'h07, 8'h00, 8'h00, 8'h00};
      send_pkt();
      wait_tx(4);
      chk("tmo_next_add", res32(), 32'h0000000C);

      // Reset after 2 of 4 result bytes
      clear();
      lim = 2;
      bp_mode = 2;
      pkt = '{8'hA8, 8'h00, 8'h0C, 8'h00,
              8'h44, 8'h33, 8'h22, 8'h11,
              8'h00, 8'h00, 8'h00, 8'h00};
      send_pkt();
      wait_tx(2);
      cyc(3);
      chk("mid_busy", {31'd0, busy_o}, 32'd1);
      chk("mid_hold", {24'd0, tx_tdata}, 32'h22);
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_valid", {31'd0, tx_tvalid}, 32'd0);
      chk("mid_rst_busy", {31'd0, busy_o}, 32'd0);
      chk("mid_rst_ready", {31'd0, rx_tready}, 32'd0);
      chk("mid_rst_err", {31'd0, err_o}, 32'd0);
      cyc(2);
      rst = 1'b1;
      bp_mode = 0;
      cyc(10);
      chk("mid_rst_count", txq.size(), 32'd2);
      chk("mid_rst_bytes", {16'd0, txq[0], txq[1]}, 32'h00004433);
      clear();
      pkt = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h5A};
      send_pkt();
      wait_tx(1);
      chk("post_rst_echo_n", txq.size(), 32'd1);
      chk("post_rst_echo", {24'd0, txq[0]}, 32'h5A);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_packet_ctrl.md
ALU_PACKET_CTRL -- requirements
Module: alu_packet_ctrl

Interface
REQ-001 The block SHALL expose one parameter: TIMEOUT_P, default 100000, idle clock cycles allowed between bytes mid-packet before abort.
REQ-002 The block SHALL have the following ports, with clock and reset first:
- clk  in  1  single system clock, all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- rx_tdata  in  8  byte from the UART receiver stream.
- rx_tvalid  in  1  rx_tdata valid.
- rx_tready  out  1  controller accepts the rx byte.
- tx_tdata  out  8  byte to the UART transmitter stream.
- tx_tvalid  out  1  tx_tdata valid.
- tx_tready  in  1  transmitter accepts the byte.
- busy_o  out  1  high whenever state is not IDLE.
- err_o  out  1  one-cycle pulse on any protocol error or timeout.

Function
REQ-003 Packet format SHALL be: opcode, reserved (ignored), len_lo, len_hi, payload; len is the total byte count including the 4 header bytes, 16-bit little-endian.
REQ-004 Opcodes SHALL be ECHO=0xEC, ADD=0xA8, SUB=0xA9; any other value is unknown.
REQ-005 A byte SHALL transfer only on a cycle with tvalid && tready high, on rx or tx.
REQ-006 tx_tdata and tx_tvalid SHALL hold stable while tx_tvalid is high and tx_tready is low.
REQ-007 The FSM SHALL have these states: IDLE, HDR1, LEN_LO, LEN_HI, ECHO_RX, ECHO_TX, OPERAND, DRAIN, SEND_RES, SEND_ERR.
REQ-008 IDLE, HDR1, LEN_LO, LEN_HI, OPERAND and DRAIN SHALL assert rx_tready; ECHO_RX SHALL assert rx_tready when its 1-byte buffer is empty; all other states SHALL hold rx_tready low.
REQ-009 IDLE SHALL latch the opcode and go to HDR1; HDR1 SHALL go to LEN_LO; LEN_LO SHALL latch len_lo; LEN_HI SHALL latch len_hi and compute remaining = len-4.
REQ-010 Dispatch on leaving LEN_HI SHALL be:
- len<4: SEND_ERR.
- ECHO with remaining=0: IDLE.
- ECHO otherwise: ECHO_RX.
- ADD/SUB with remaining>=4 and remaining%4==0: OPERAND.
- any other case with remaining=0: SEND_ERR.
- otherwise: DRAIN.
REQ-011 ECHO SHALL move each payload byte through a 1-byte buffer (ECHO_RX capture, ECHO_TX send) in received order, then return to IDLE after the last byte is sent.
REQ-012 OPERAND SHALL assemble 32-bit words LSB first.
REQ-013 The first word SHALL load the accumulator; each later word SHALL add (ADD) or subtract (SUB) from it, modulo 2^32 with no overflow flag.
REQ-014 When remaining reaches 0, OPERAND SHALL go to SEND_RES.
REQ-015 SEND_RES SHALL send the accumulator as 4 bytes, LSB first, then return to IDLE.
REQ-016 DRAIN SHALL consume the remaining payload bytes without forwarding them, then go to SEND_ERR.
REQ-017 SEND_ERR SHALL send the single byte 0xEE, pulse err_o on entry, then return to IDLE.
REQ-018 A byte counter SHALL be reloaded on every rx transfer. If it reaches TIMEOUT_P in HDR1, LEN_LO, LEN_HI, ECHO_RX, OPERAND or DRAIN, the FSM SHALL go to IDLE, discard partial data, send nothing and pulse err_o.
REQ-019 The timeout counter SHALL be frozen in IDLE and in all transmit states.
REQ-020 Latency SHALL be as follows:
- first result or error byte: tx_tvalid rises 1 cycle after the final rx transfer.
- echo: tx_tvalid rises 1 cycle after each rx transfer.
REQ-021 A new packet SHALL be accepted in the cycle after the last tx transfer of the previous one; the IDLE-return cycle SHALL accept an rx byte.

Reset
REQ-022 While rst is low at a rising edge of clk, the block SHALL force state IDLE, accumulator 0, counters 0, echo buffer empty.
REQ-023 While rst is low, tx_tvalid, err_o, busy_o and rx_tready SHALL all be 0; after release, rx_tready SHALL be 1 from the next cycle.
REQ-024 Reset asserted mid-packet or mid-transmit SHALL drop the packet with no further tx bytes.

Verification
REQ-025 ADD: A8 00 0C 00 01 00 00 00 02 00 00 00 -> tx 03 00 00 00; err_o stays 0.
REQ-026 SUB wrap: A9 00 0C 00 00 00 00 00 01 00 00 00 -> tx FF FF FF FF; ADD FF FF FF FF + 02 00 00 00 -> tx 01 00 00 00.
REQ-027 ECHO under backpressure: EC 00 07 00 41 42 43 with tx_tready low 50 cycles per byte -> tx 41 42 43, in order, none lost or duplicated.
REQ-028 Errors:
- 55 00 06 00 AA BB -> 2 payload bytes drained, tx EE, one err_o pulse.
- A8 00 06 00 11 22 -> tx EE.
- A8 00 02 00 -> tx EE.
REQ-029 Timeout: send A8 00 0C 00 01, then idle TIMEOUT_P cycles -> err_o pulse, no tx bytes; a following valid ADD packet returns the correct sum.
REQ-030 Reset mid-SEND_RES after 2 result bytes -> no further tx bytes, outputs match REQ-023, and the next ECHO packet works.
